axis_producer_consumer: RTL and testbench
=========================================

# axis_producer_consumer

Self-contained AXI-Stream loopback block: a producer generates a counting data stream, and a consumer accepts it under a fixed back-pressure pattern. The consumer registers each accepted beat into `out1_reg`, counts beats and packets, and flags sequence errors. The block serves as the reference streaming pipeline for exercising the team's AXIS interface bundle (tdata/tvalid/tready/tlast) between two modules on one clock.

## Interface
- `WIDTH`, default 64: tdata width in bits; also the width of `out1_reg`.
- `PKT_LEN`, default 8: beats per packet; `tlast` is asserted on the last beat. Legal range ≥ 1.
- `READY_PERIOD`, default 4: consumer back-pressure period, with `tready` low for 1 cycle in every `READY_PERIOD`. Value 0 disables back-pressure. Otherwise legal range ≥ 2.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-low. It is sampled on the `clk` rising edge; `rst`=0 resets all state.
- `out1_reg`, output, WIDTH: tdata of the most recently accepted beat.
- `beat_count`, output, 32: number of accepted beats, wrapping modulo 2^32.
- `pkt_count`, output, 32: number of accepted beats with tlast=1, wrapping modulo 2^32.
- `seq_err`, output, 1: sticky error flag.
- `axis_tvalid`, `axis_tready`, `axis_tlast`, output, 1 each: monitor copies of the internal handshake signals.

## Operation
- **Transfer rule:** a beat transfers on a rising edge where tvalid=1 and tready=1, both sampled before the edge.
- **Producer registers:**
  - tvalid: resets to 0.
  - tdata: resets to 1.
  - beat index `idx`: resets to 0, counts 0..PKT_LEN-1.
- **Producer behaviour:**
  - On the first edge with `rst`=1, tvalid becomes 1 and then stays 1 (continuous source).
  - On each transfer: tdata ← tdata+1, modulo 2^WIDTH, so all-ones wraps to 0.
  - On each transfer: idx ← (idx==PKT_LEN-1) ? 0 : idx+1.
  - tlast = (idx==PKT_LEN-1), combinational from idx.
  - While tvalid=1 and tready=0, tdata, tlast and tvalid hold unchanged (AXIS stability rule).
- **Consumer phase counter (READY_PERIOD ≥ 2):**
  - `phase` resets to READY_PERIOD-1.
  - On each non-reset edge, phase ← (phase+1) mod READY_PERIOD.
  - tready = (phase != READY_PERIOD-1), so tready is 0 during reset.
- **Consumer, READY_PERIOD = 0:** a registered `active` flag resets to 0 and is set on the first non-reset edge; tready = `active`.
- **Consumer, on each transfer:**
  - out1_reg ← tdata.
  - beat_count ← beat_count+1.
  - pkt_count ← pkt_count+1 when tlast=1.
- **Consumer checking:**
  - The consumer keeps an expected value `exp`, which resets to 1 and becomes tdata+1 (mod 2^WIDTH) on each transfer.
  - It keeps its own beat index, tracked like the producer's.
  - seq_err ← 1 on a transfer where tdata≠exp, or where tlast≠(consumer index==PKT_LEN-1).
  - seq_err is cleared only by reset.
- **Reset values:**
  - `out1_reg`=0, `beat_count`=0, `pkt_count`=0, `seq_err`=0.
  - `axis_tvalid`=0, `axis_tready`=0.
  - `axis_tlast`=1 if PKT_LEN==1, else 0.
- **Reset mid-stream:** on the next edge all state returns to its reset values regardless of handshake state, and the stream restarts at tdata=1.

## Timing
- Number the edges E1, E2, … starting with the first rising edge where `rst`=1.
- **E1:** tvalid←1 and tready←1. No transfer occurs at E1, because both signals were 0 before the edge.
- **First transfer:** occurs at E2. `out1_reg` = 1 after E2, so latency from reset release to first visible data is 2 cycles.
- **Steady state with the default READY_PERIOD=4:**
  - Transfers at E2, E3, E4; none at E5; then E6, E7, E8; none at E9; and so on.
  - `out1_reg` after E2..E6 = 1, 2, 3, 3, 4.
- **Data-to-output latency:** `out1_reg`, `beat_count` and `pkt_count` update on the same edge as the transfer (1-cycle registered).
- **Back-pressure disabled (READY_PERIOD=0):** one beat per cycle from E2 onward.
- **No combinational paths** from inputs to outputs other than through registers. tlast and tready are decoded from registers only.

## Test plan
- **Reset hold:** `rst`=0 for 3 cycles → `out1_reg`=0, counts=0, `axis_tvalid`=0, `axis_tready`=0, `seq_err`=0.
- **Start-up:** release reset, defaults → `out1_reg` after E2..E6 = 1, 2, 3, 3, 4; `axis_tready` low exactly before E5 and E9.
- **Packet boundary:** run 40 cycles → `axis_tlast` high only while tdata ∈ {8, 16, 24}; `pkt_count`=3 once beat 24 is accepted; `beat_count` equals `out1_reg`.
- **No back-pressure:** READY_PERIOD=0, run 10 edges → `out1_reg`=9 after E10, `beat_count`=9, `seq_err`=0.
- **Wrap-around:** WIDTH=4, READY_PERIOD=0 → `out1_reg` sequence …14, 15, 0, 1…; `seq_err` stays 0.
- **Reset mid-stream:** assert `rst`=0 for 1 cycle after E7, with `axis_tvalid`=1 and `axis_tready`=0 if aligned → all outputs return to reset values; after release, the next accepted beat is 1.

Source files
------------

// File: rtl/axis_producer_consumer.sv
// axis_producer_consumer: counting AXI-Stream source looped into a checking sink.
// Both stages share one clock and a synchronous active-low reset.

module axis_producer_stage #(
   parameter int WIDTH   = 64,
   parameter int PKT_LEN = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tready,
   output logic             tvalid,
   output logic [WIDTH-1:0] tdata,
   output logic             tlast
);
   localparam int IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [IW-1:0] LAST = IW'(PKT_LEN - 1);

   logic [IW-1:0] idx;

   assign tlast = (idx == LAST);

   // tdata/idx only move on a handshake, so a stalled beat stays stable
   always_ff @(posedge clk) begin
      if (!rst) begin
         tvalid <= 1'b0;
         tdata  <= WIDTH'(1);
         idx    <= '0;
      end else begin
         tvalid <= 1'b1;
         if (tvalid && tready) begin
            tdata <= tdata + WIDTH'(1);
            idx   <= (idx == LAST) ? '0 : idx + IW'(1);
         end
      end
   end
endmodule

module axis_consumer_stage #(
   parameter int WIDTH        = 64,
   parameter int PKT_LEN      = 8,
   parameter int READY_PERIOD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tvalid,
   input  logic [WIDTH-1:0] tdata,
   input  logic             tlast,
   output logic             tready,
   output logic [WIDTH-1:0] out1_reg,
   output logic [31:0]      beat_count,
   output logic [31:0]      pkt_count,
   output logic             seq_err
);
   localparam int IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [IW-1:0] LAST = IW'(PKT_LEN - 1);

   logic             xfer;
   logic             tlast_exp;
   logic [WIDTH-1:0] exp_data;
   logic [IW-1:0]    cidx;

   generate
      if (READY_PERIOD == 0) begin : g_free
         logic active;

         always_ff @(posedge clk) begin
            if (!rst) active <= 1'b0;
            else      active <= 1'b1;
         end

         assign tready = active;
      end else begin : g_bp
         localparam int PW = $clog2(READY_PERIOD);
         localparam logic [PW-1:0] PLAST = PW'(READY_PERIOD - 1);

         logic [PW-1:0] phase;

         // last phase of each period is the stall slot
         always_ff @(posedge clk) begin
            if (!rst)               phase <= PLAST;
            else if (phase == PLAST) phase <= '0;
            else                    phase <= phase + PW'(1);
         end

         assign tready = (phase != PLAST);
      end
   endgenerate

   assign xfer      = tvalid && tready;
   assign tlast_exp = (cidx == LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         out1_reg   <= '0;
         beat_count <= '0;
         pkt_count  <= '0;
         seq_err    <= 1'b0;
         exp_data   <= WIDTH'(1);
         cidx       <= '0;
      end else if (xfer) begin
         out1_reg   <= tdata;
         beat_count <= beat_count + 32'd1;
         if (tlast)
            pkt_count <= pkt_count + 32'd1;
         exp_data   <= tdata + WIDTH'(1);
         cidx       <= (cidx == LAST) ? '0 : cidx + IW'(1);
         if ((tdata != exp_data) || (tlast != tlast_exp))
            seq_err <= 1'b1;
      end
   end
endmodule

module axis_producer_consumer #(
   parameter int WIDTH        = 64,
   parameter int PKT_LEN      = 8,
   parameter int READY_PERIOD = 4
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] out1_reg,
   output logic [31:0]      beat_count,
   output logic [31:0]      pkt_count,
   output logic             seq_err,
   output logic             axis_tvalid,
   output logic             axis_tready,
   output logic             axis_tlast
);
   logic             tvalid;
   logic             tready;
   logic             tlast;
   logic [WIDTH-1:0] tdata;

   axis_producer_stage #(
      .WIDTH   (WIDTH),
      .PKT_LEN (PKT_LEN)
   ) u_prod (
      .clk    (clk),
      .rst    (rst),
      .tready (tready),
      .tvalid (tvalid),
      .tdata  (tdata),
      .tlast  (tlast)
   );

   axis_consumer_stage #(
      .WIDTH        (WIDTH),
      .PKT_LEN      (PKT_LEN),
      .READY_PERIOD (READY_PERIOD)
   ) u_cons (
      .clk        (clk),
      .rst        (rst),
      .tvalid     (tvalid),
      .tdata      (tdata),
      .tlast      (tlast),
      .tready     (tready),
      .out1_reg   (out1_reg),
      .beat_count (beat_count),
      .pkt_count  (pkt_count),
      .seq_err    (seq_err)
   );

   assign axis_tvalid = tvalid;
   assign axis_tready = tready;
   assign axis_tlast  = tlast;
endmodule

// File: tb/tb_axis_producer_consumer.sv
// tb_axis_producer_consumer: three configurations driven by one reset,
// compared each cycle against an edge-count/beat-count reference model.

module tb_axis_producer_consumer;
   logic clk;
   logic rst;

   logic [63:0] out_d, out_f;
   logic [3:0]  out_w;
   logic [31:0] bc_d, bc_f, bc_w;
   logic [31:0] pc_d, pc_f, pc_w;
   logic        se_d, se_f, se_w;
   logic        tv_d, tv_f, tv_w;
   logic        tr_d, tr_f, tr_w;
   logic        tl_d, tl_f, tl_w;

   int errors;
   int checks;

   int          rp[3];
   int unsigned n_edges[3];
   int unsigned beats[3];
   int          start_exp[5];
   int          wrap_exp[3];
   int          len;

   axis_producer_consumer u_dut (
      .clk(clk), .rst(rst),
      .out1_reg(out_d), .beat_count(bc_d), .pkt_count(pc_d),
      .seq_err(se_d), .axis_tvalid(tv_d),
      .axis_tready(tr_d), .axis_tlast(tl_d)
   );

   axis_producer_consumer #(.READY_PERIOD(0)) u_free (
      .clk(clk), .rst(rst),
      .out1_reg(out_f), .beat_count(bc_f), .pkt_count(pc_f),
      .seq_err(se_f), .axis_tvalid(tv_f),
      .axis_tready(tr_f), .axis_tlast(tl_f)
   );

   axis_producer_consumer #(.WIDTH(4), .READY_PERIOD(0)) u_wrap (
      .clk(clk), .rst(rst),
      .out1_reg(out_w), .beat_count(bc_w), .pkt_count(pc_w),
      .seq_err(se_w), .axis_tvalid(tv_w),
      .axis_tready(tr_w), .axis_tlast(tl_w)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ready after n non-reset edges: stall slot is every rp-th cycle from E4
   function automatic bit rdy(input int p, input int unsigned n);
      if (n == 0) return 1'b0;
      if (p == 0) return 1'b1;
      return ((n - 1) % p) != p - 1;
   endfunction

   task automatic model_edge(input logic r);
      for (int i = 0; i < 3; i++) begin
         if (!r) begin
            n_edges[i] = 0;
            beats[i]   = 0;
         end else begin
            if (n_edges[i] >= 1 && rdy(rp[i], n_edges[i]))
               beats[i]++;
            n_edges[i]++;
         end
      end
   endtask

   task automatic check_all();
      logic [63:0] o;
      logic [31:0] b, p;
      logic        s, v, t, l;
      logic [63:0] eo;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: begin o = out_d; b = bc_d; p = pc_d; s = se_d;
                     v = tv_d; t = tr_d; l = tl_d; end
            1: begin o = out_f; b = bc_f; p = pc_f; s = se_f;
                     v = tv_f; t = tr_f; l = tl_f; end
            default: begin o = 64'(out_w); b = bc_w; p = pc_w; s = se_w;
                     v = tv_w; t = tr_w; l = tl_w; end
         endcase
         eo = 64'(beats[i]);
         if (i == 2) eo = eo & 64'hF;
         chk($sformatf("out%0d", i), o, eo);
         chk($sformatf("beats%0d", i), 64'(b), 64'(beats[i]));
         chk($sformatf("pkts%0d", i), 64'(p), 64'(beats[i] / 8));
         chk($sformatf("seqerr%0d", i), 64'(s), 64'd0);
         chk($sformatf("tvalid%0d", i), 64'(v), 64'(n_edges[i] >= 1));
         chk($sformatf("tready%0d", i), 64'(t),
             64'(rdy(rp[i], n_edges[i])));
         chk($sformatf("tlast%0d", i), 64'(l),
             64'(((beats[i] + 1) % 8) == 0));
      end
   endtask

   task automatic step(input logic r);
      rst = r;
      @(posedge clk);
      model_edge(r);
      #1;
      check_all();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rp = '{4, 0, 0};
      n_edges = '{0, 0, 0};
      beats = '{0, 0, 0};
      start_exp = '{1, 2, 3, 3, 4};
      wrap_exp = '{14, 15, 0};
      rst = 1'b0;

      for (int k = 0; k < 3; k++) step(1'b0);
      chk("rst_out", out_d, 64'd0);
      chk("rst_beats", 64'(bc_d), 64'd0);
      chk("rst_tvalid", 64'(tv_d), 64'd0);
      chk("rst_tready", 64'(tr_d), 64'd0);
      chk("rst_seqerr", 64'(se_d), 64'd0);

      for (int e = 1; e <= 40; e++) begin
         step(1'b1);
         if (e >= 2 && e <= 6)
            chk("start_out", out_d, 64'(start_exp[e-2]));
         if (e == 4 || e == 8)
            chk("bp_tready", 64'(tr_d), 64'd0);
         if (e == 10) begin
            chk("free_out", out_f, 64'd9);
            chk("free_beats", 64'(bc_f), 64'd9);
         end
         if (e >= 15 && e <= 17)
            chk("wrap_out", 64'(out_w), 64'(wrap_exp[e-15]));
         if (e == 40)
            chk("pkt_cnt", 64'(pc_d), 64'd3);
      end

      // reset while the stream is running
      step(1'b0);
      for (int e = 1; e <= 7; e++) step(1'b1);
      step(1'b0);
      chk("mid_out", out_d, 64'd0);
      chk("mid_tvalid", 64'(tv_d), 64'd0);
      chk("mid_tready", 64'(tr_d), 64'd0);
      step(1'b1);
      step(1'b1);
      chk("restart_out", out_d, 64'd1);

      for (int r = 0; r < 20; r++) begin
         len = int'($urandom_range(1, 40));
         for (int k = 0; k < len; k++) step(1'b1);
         len = int'($urandom_range(1, 3));
         for (int k = 0; k < len; k++) step(1'b0);
      end
      for (int k = 0; k < 30; k++) step(1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
